// File: rtl/multicycle_control_pkg.sv
// multicycle_control_pkg
// Shared definitions for the LEGv8 multi-cycle controller and its datapath
// neighbours (SignExtender, ALU): opcode constants, ALU op codes,
// sign-extender control codes, FSM state encoding, trap causes and the
// decoded-control record produced by the instruction decoder.
package multicycle_control_pkg;

    // FSM state encoding
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_t;

    // Instruction classes; each class takes a distinct path through the FSM
    typedef enum logic [2:0] {
        CLS_R    = 3'd0,
        CLS_I    = 3'd1,
        CLS_LDUR = 3'd2,
        CLS_STUR = 3'd3,
        CLS_CBZ  = 3'd4,
        CLS_B    = 3'd5
    } iclass_t;

    // Opcodes, ir[31:21]
    localparam logic [10:0] OP_ADD  = 11'h458;
    localparam logic [10:0] OP_SUB  = 11'h658;
    localparam logic [10:0] OP_AND  = 11'h450;
    localparam logic [10:0] OP_ORR  = 11'h550;
    localparam logic [10:0] OP_LDUR = 11'h7C2;
    localparam logic [10:0] OP_STUR = 11'h7C0;

    // Opcodes whose low bits belong to the immediate field: match the
    // upper bits only.
    localparam logic [9:0]  OP_ADDI_HI = 10'h244;   // 488/489
    localparam logic [9:0]  OP_SUBI_HI = 10'h344;   // 688/689
    localparam logic [7:0]  OP_CBZ_HI  = 8'hB4;     // 5A0-5A7
    localparam logic [5:0]  OP_B_HI    = 6'h05;     // 0A0-0BF

    // ALU operation codes
    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_ORR   = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b0111;

    // SignExtender Ctrl codes
    localparam logic [1:0] SEXT_I  = 2'b00;
    localparam logic [1:0] SEXT_D  = 2'b01;
    localparam logic [1:0] SEXT_B  = 2'b10;
    localparam logic [1:0] SEXT_CB = 2'b11;

    // Trap causes
    localparam logic [1:0] TRAP_NONE    = 2'b00;
    localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
    localparam logic [1:0] TRAP_IMEM_TO = 2'b10;
    localparam logic [1:0] TRAP_DMEM_TO = 2'b11;

    // Decoded control record
    typedef struct packed {
        logic        legal;
        iclass_t     cls;
        logic [1:0]  sext_ctrl;
        logic [3:0]  alu_op;
        logic        alu_src;
        logic        reg2loc;
        logic        mem_to_reg;
    } ctrl_t;

    // Classes that need a data-memory access
    function automatic logic is_mem_class(input iclass_t c);
        return (c == CLS_LDUR) || (c == CLS_STUR);
    endfunction

endpackage

// File: rtl/multicycle_control_instr_decoder.sv
// multicycle_control_instr_decoder
// Purely combinational opcode decoder: maps ir[31:21] onto the control
// record used by the sequencing FSM.
// Ports:
//   opcode  in   11  ir[31:21]
//   ctrl    out  ctrl_t  {legal, class, sext_ctrl, alu_op, alu_src,
//                        reg2loc, mem_to_reg}; all zero when illegal
module multicycle_control_instr_decoder
    import multicycle_control_pkg::*;
(
    input  logic [10:0] opcode,
    output ctrl_t       ctrl
);

    logic        legal;
    iclass_t     cls;
    logic [3:0]  arith_op;

    // Classification and arithmetic flavour
    always_comb begin
        legal    = 1'b1;
        cls      = CLS_R;
        arith_op = ALU_ADD;
        if (opcode == OP_ADD) begin
            arith_op = ALU_ADD;
        end else if (opcode == OP_SUB) begin
            arith_op = ALU_SUB;
        end else if (opcode == OP_AND) begin
            arith_op = ALU_AND;
        end else if (opcode == OP_ORR) begin
            arith_op = ALU_ORR;
        end else if (opcode[10:1] == OP_ADDI_HI) begin
            cls      = CLS_I;
            arith_op = ALU_ADD;
        end else if (opcode[10:1] == OP_SUBI_HI) begin
            cls      = CLS_I;
            arith_op = ALU_SUB;
        end else if (opcode == OP_LDUR) begin
            cls = CLS_LDUR;
        end else if (opcode == OP_STUR) begin
            cls = CLS_STUR;
        end else if (opcode[10:3] == OP_CBZ_HI) begin
            cls = CLS_CBZ;
        end else if (opcode[10:5] == OP_B_HI) begin
            cls = CLS_B;
        end else begin
            legal = 1'b0;
        end
    end

    // Per-class datapath controls
    always_comb begin
        ctrl       = '0;
        ctrl.legal = legal;
        ctrl.cls   = cls;
        case (cls)
            CLS_R: begin
                ctrl.alu_op = arith_op;
            end
            CLS_I: begin
                ctrl.sext_ctrl = SEXT_I;
                ctrl.alu_op    = arith_op;
                ctrl.alu_src   = 1'b1;
            end
            CLS_LDUR: begin
                ctrl.sext_ctrl  = SEXT_D;
                ctrl.alu_op     = ALU_ADD;
                ctrl.alu_src    = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            CLS_STUR: begin
                ctrl.sext_ctrl = SEXT_D;
                ctrl.alu_op    = ALU_ADD;
                ctrl.alu_src   = 1'b1;
                ctrl.reg2loc   = 1'b1;
            end
            CLS_CBZ: begin
                // Rt is passed straight through so the ALU zero flag tests it
                ctrl.sext_ctrl = SEXT_CB;
                ctrl.alu_op    = ALU_PASSB;
                ctrl.reg2loc   = 1'b1;
            end
            CLS_B: begin
                ctrl.sext_ctrl = SEXT_B;
                ctrl.alu_op    = ALU_PASSB;
            end
            default: ctrl = '0;
        endcase
        if (!legal) begin
            ctrl = '0;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control
// Multi-cycle control FSM for the LEGv8 subset CPU. Sequences
// FETCH/DECODE/EXEC/MEM/WB over the shared datapath, latches the
// instruction, drives datapath controls and memory handshakes, traps on
// illegal opcodes or memory timeouts and counts retired instructions.
// Parameters:
//   TIMEOUT  max cycles waiting for an ack before trapping (>= 2)
//   CNT_W    width of the retired-instruction counter
// Ports:
//   CLK, resetl             clock; synchronous active-low reset
//   imem_req/ack/rdata      instruction fetch handshake
//   dmem_req/we/ack         data memory handshake (we=1 for STUR)
//   ir                      latched instruction
//   sext_ctrl, alu_op, alu_src, reg2loc, mem_to_reg   datapath controls
//   reg_write, pc_write     one-cycle strobes
//   zero                    ALU zero flag, used by CBZ in EXEC
//   pc_src                  0 = PC+4, 1 = PC + (BusImm << 2)
//   trap, trap_cause        sticky error flag and its cause
//   retired                 retired-instruction count (wraps)
//
// state  | meaning
// IDLE   | one cycle after reset, then fetch
// FETCH  | imem_req held, waiting for imem_ack (timed)
// DECODE | latch decoded controls, trap if illegal
// EXEC   | branch resolution; route to MEM or WB
// MEM    | dmem_req held, waiting for dmem_ack (timed)
// WB     | register write and PC+4
// TRAP   | absorbing until reset
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             CLK,
    input  logic             resetl,
    output logic             imem_req,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    output logic [31:0]      ir,
    output logic [1:0]       sext_ctrl,
    output logic [3:0]       alu_op,
    output logic             alu_src,
    output logic             reg2loc,
    output logic             mem_to_reg,
    output logic             reg_write,
    input  logic             zero,
    output logic             pc_write,
    output logic             pc_src,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] retired
);

    localparam int            TW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    state_t        state;
    iclass_t       cls;
    ctrl_t         dec;
    logic [TW-1:0] tcnt;
    logic          pc_write_r;
    logic          pc_src_r;
    logic          cbz_exec;
    logic          stur_done;

    multicycle_control_instr_decoder u_instr_decoder (
        .opcode (ir[31:21]),
        .ctrl   (dec)
    );

    // Two strobe terms cannot be registered ahead of time: a STUR retires
    // in the very cycle its dmem_ack arrives, and CBZ takes its direction
    // from the zero flag the ALU produces during EXEC. dmem_req and dmem_we
    // are only high in MEM, and cbz_exec only in EXEC of a CBZ, so these
    // terms are confined to those cycles. resetl gates the store term so a
    // reset landing on the ack cycle retires nothing.
    assign stur_done = resetl & dmem_req & dmem_we & dmem_ack;
    assign pc_write  = pc_write_r | stur_done;
    assign pc_src    = cbz_exec ? zero : pc_src_r;

    always_ff @(posedge CLK) begin
        if (!resetl) begin
            state      <= ST_IDLE;
            cls        <= CLS_R;
            ir         <= '0;
            tcnt       <= '0;
            imem_req   <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            sext_ctrl  <= '0;
            alu_op     <= '0;
            alu_src    <= 1'b0;
            reg2loc    <= 1'b0;
            mem_to_reg <= 1'b0;
            reg_write  <= 1'b0;
            pc_write_r <= 1'b0;
            pc_src_r   <= 1'b0;
            cbz_exec   <= 1'b0;
            trap       <= 1'b0;
            trap_cause <= TRAP_NONE;
            retired    <= '0;
        end else begin
            reg_write  <= 1'b0;
            pc_write_r <= 1'b0;
            cbz_exec   <= 1'b0;

            // The count moves at the end of the strobe cycle.
            if (pc_write) begin
                retired <= retired + CNT_W'(1);
            end

            case (state)
                ST_IDLE: begin
                    state    <= ST_FETCH;
                    imem_req <= 1'b1;
                    tcnt     <= '0;
                end

                ST_FETCH: begin
                    // ack beats expiry when both land in the same cycle
                    if (imem_ack) begin
                        ir       <= imem_rdata;
                        imem_req <= 1'b0;
                        state    <= ST_DECODE;
                    end else if (tcnt == TLAST) begin
                        imem_req   <= 1'b0;
                        trap       <= 1'b1;
                        trap_cause <= TRAP_IMEM_TO;
                        state      <= ST_TRAP;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end

                ST_DECODE: begin
                    if (!dec.legal) begin
                        trap       <= 1'b1;
                        trap_cause <= TRAP_ILLEGAL;
                        state      <= ST_TRAP;
                    end else begin
                        cls        <= dec.cls;
                        sext_ctrl  <= dec.sext_ctrl;
                        alu_op     <= dec.alu_op;
                        alu_src    <= dec.alu_src;
                        reg2loc    <= dec.reg2loc;
                        mem_to_reg <= dec.mem_to_reg;
                        // Branches retire in EXEC, so their strobe is set up here.
                        pc_write_r <= (dec.cls == CLS_B) || (dec.cls == CLS_CBZ);
                        pc_src_r   <= (dec.cls == CLS_B);
                        cbz_exec   <= (dec.cls == CLS_CBZ);
                        state      <= ST_EXEC;
                    end
                end

                ST_EXEC: begin
                    if ((cls == CLS_B) || (cls == CLS_CBZ)) begin
                        if (cls == CLS_CBZ) begin
                            pc_src_r <= zero;   // hold the direction taken
                        end
                        imem_req <= 1'b1;
                        tcnt     <= '0;
                        state    <= ST_FETCH;
                    end else if (is_mem_class(cls)) begin
                        dmem_req <= 1'b1;
                        dmem_we  <= (cls == CLS_STUR);
                        tcnt     <= '0;
                        state    <= ST_MEM;
                    end else begin
                        reg_write  <= 1'b1;
                        pc_write_r <= 1'b1;
                        pc_src_r   <= 1'b0;
                        state      <= ST_WB;
                    end
                end

                ST_MEM: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        if (cls == CLS_STUR) begin
                            imem_req <= 1'b1;
                            tcnt     <= '0;
                            state    <= ST_FETCH;
                        end else begin
                            reg_write  <= 1'b1;
                            pc_write_r <= 1'b1;
                            pc_src_r   <= 1'b0;
                            state      <= ST_WB;
                        end
                    end else if (tcnt == TLAST) begin
                        dmem_req   <= 1'b0;
                        dmem_we    <= 1'b0;
                        trap       <= 1'b1;
                        trap_cause <= TRAP_DMEM_TO;
                        state      <= ST_TRAP;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end

                ST_WB: begin
                    imem_req <= 1'b1;
                    tcnt     <= '0;
                    state    <= ST_FETCH;
                end

                ST_TRAP: begin
                    state <= ST_TRAP;
                end

                default: begin
                    imem_req <= 1'b0;
                    dmem_req <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control. A reference model derived from the opcode
// table and the per-class cycle budget predicts, for each instruction,
// how many request cycles are seen, when the strobes fire, which controls
// are presented, and how the retired count evolves.
module tb_multicycle_control;

    localparam int TO = 4;
    localparam int C_ILL = 0, C_R = 1, C_I = 2, C_LD = 3, C_ST = 4, C_CBZ = 5, C_B = 6;
    localparam int NEVER = 99;

    logic        CLK = 1'b0;
    logic        resetl = 1'b0;
    logic        imem_req, imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        dmem_req, dmem_we, dmem_ack = 1'b0;
    logic [31:0] ir;
    logic [1:0]  sext_ctrl;
    logic [3:0]  alu_op;
    logic        alu_src, reg2loc, mem_to_reg, reg_write;
    logic        zero = 1'b0;
    logic        pc_write, pc_src, trap;
    logic [1:0]  trap_cause;
    logic [31:0] retired;

    int total = 0;
    int bad = 0;
    int exp_retired = 0;

    // results of the last trace
    int t_c, t_nri, t_nrd, t_pcw, t_rwn, t_rwat, t_trap, t_webad;
    logic        c_pcs, c_alusrc, c_r2l, c_m2r;
    logic [1:0]  c_sext;
    logic [3:0]  c_aluop;
    logic [31:0] c_ir;

    multicycle_control #(.TIMEOUT(TO), .CNT_W(32)) dut (
        .CLK(CLK), .resetl(resetl),
        .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .ir(ir), .sext_ctrl(sext_ctrl), .alu_op(alu_op), .alu_src(alu_src),
        .reg2loc(reg2loc), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .zero(zero), .pc_write(pc_write), .pc_src(pc_src),
        .trap(trap), .trap_cause(trap_cause), .retired(retired)
    );

    always #5 CLK = ~CLK;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish (bad=%0d)", bad);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int classify(input logic [10:0] op);
        if (op == 11'h458 || op == 11'h658 || op == 11'h450 || op == 11'h550) return C_R;
        if (op == 11'h488 || op == 11'h489 || op == 11'h688 || op == 11'h689) return C_I;
        if (op == 11'h7C2) return C_LD;
        if (op == 11'h7C0) return C_ST;
        if (op >= 11'h5A0 && op <= 11'h5A7) return C_CBZ;
        if (op >= 11'h0A0 && op <= 11'h0BF) return C_B;
        return C_ILL;
    endfunction

    function automatic logic [3:0] model_alu(input logic [10:0] op, input int cls);
        if (cls == C_R) begin
            if (op == 11'h458) return 4'b0010;
            if (op == 11'h658) return 4'b0110;
            if (op == 11'h450) return 4'b0000;
            return 4'b0001;
        end
        if (cls == C_I) return (op >= 11'h688) ? 4'b0110 : 4'b0010;
        if (cls == C_CBZ) return 4'b0111;
        return 4'b0010;
    endfunction

    function automatic logic [1:0] model_sext(input int cls);
        if (cls == C_LD || cls == C_ST) return 2'b01;
        if (cls == C_B) return 2'b10;
        if (cls == C_CBZ) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [10:0] pick_op(input int cls);
        case (cls)
            C_R: begin
                case ($urandom_range(0, 3))
                    0: return 11'h458;
                    1: return 11'h658;
                    2: return 11'h450;
                    default: return 11'h550;
                endcase
            end
            C_I:   return ($urandom_range(0, 1) == 1 ? 11'h688 : 11'h488) + 11'($urandom_range(0, 1));
            C_LD:  return 11'h7C2;
            C_ST:  return 11'h7C0;
            C_CBZ: return 11'h5A0 + 11'($urandom_range(0, 7));
            default: return 11'h0A0 + 11'($urandom_range(0, 31));
        endcase
    endfunction

    // Drives one instruction from a FETCH cycle until it retires, traps or
    // the budget runs out. Acks are raised after fdly/mdly waiting cycles;
    // outside a request, acks and rdata are noise that must be ignored.
    task automatic trace(input logic [31:0] ins, input int fdly, input int mdly,
                         input logic z, input logic exp_we);
        t_c = 0; t_nri = 0; t_nrd = 0; t_pcw = 0; t_rwn = 0; t_rwat = 0;
        t_trap = 0; t_webad = 0;
        zero = z;
        while (t_pcw == 0 && t_trap == 0 && t_c < 40) begin
            t_c++;
            if (imem_req) begin
                imem_ack = (t_nri == fdly);
                t_nri++;
            end else begin
                imem_ack = 1'($urandom_range(0, 1));
            end
            imem_rdata = (imem_req && imem_ack) ? ins : $urandom;
            if (dmem_req) begin
                dmem_ack = (t_nrd == mdly);
                t_nrd++;
                if (dmem_we !== exp_we) t_webad++;
            end else begin
                dmem_ack = 1'($urandom_range(0, 1));
            end
            #1;
            if (reg_write) begin
                t_rwn++;
                t_rwat = t_c;
            end
            if (pc_write) begin
                t_pcw = t_c;
                c_pcs = pc_src; c_sext = sext_ctrl; c_aluop = alu_op;
                c_alusrc = alu_src; c_r2l = reg2loc; c_m2r = mem_to_reg; c_ir = ir;
            end
            if (trap) t_trap = t_c;
            @(negedge CLK);
        end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
    endtask

    task automatic run_instr(input string tag, input logic [31:0] ins, input int fdly,
                             input int mdly, input logic z);
        logic [10:0] op;
        int cls, exp_pcw;
        logic wb, mem;
        op  = ins[31:21];
        cls = classify(op);
        wb  = (cls == C_R || cls == C_I || cls == C_LD);
        mem = (cls == C_LD || cls == C_ST);
        // cycles from the first FETCH cycle to the strobe cycle
        exp_pcw = fdly + 1 + 2;
        if (cls == C_R || cls == C_I) exp_pcw += 1;
        if (mem) exp_pcw += mdly + 1;
        if (cls == C_LD) exp_pcw += 1;

        chk({tag, "/retired_before"}, retired, 32'(exp_retired));
        trace(ins, fdly, mdly, z, cls == C_ST);
        chk({tag, "/pc_write_cycle"}, 32'(t_pcw), 32'(exp_pcw));
        chk({tag, "/imem_req_cycles"}, 32'(t_nri), 32'(fdly + 1));
        chk({tag, "/dmem_req_cycles"}, 32'(t_nrd), mem ? 32'(mdly + 1) : 32'd0);
        chk({tag, "/trap"}, 32'(t_trap), 32'd0);
        chk({tag, "/reg_write_count"}, 32'(t_rwn), wb ? 32'd1 : 32'd0);
        chk({tag, "/pc_src"}, 32'(c_pcs), (cls == C_B) ? 32'd1 : (cls == C_CBZ) ? 32'(z) : 32'd0);
        chk({tag, "/ir"}, c_ir, ins);
        if (mem) chk({tag, "/dmem_we"}, 32'(t_webad), 32'd0);
        if (wb) begin
            chk({tag, "/reg_write_cycle"}, 32'(t_rwat), 32'(exp_pcw));
            chk({tag, "/mem_to_reg"}, 32'(c_m2r), 32'(cls == C_LD));
        end
        if (cls != C_R) chk({tag, "/sext_ctrl"}, 32'(c_sext), 32'(model_sext(cls)));
        if (cls != C_B) begin
            chk({tag, "/alu_op"}, 32'(c_aluop), 32'(model_alu(op, cls)));
            chk({tag, "/alu_src"}, 32'(c_alusrc), 32'(cls == C_I || mem));
            chk({tag, "/reg2loc"}, 32'(c_r2l), 32'(cls == C_ST || cls == C_CBZ));
        end
        exp_retired++;
    endtask

    // Trap must be absorbing: no requests, no strobes, cause held.
    task automatic hold_trap(input string tag, input logic [1:0] cause);
        int viol = 0;
        for (int k = 0; k < 6; k++) begin
            imem_ack = 1'($urandom_range(0, 1));
            dmem_ack = 1'($urandom_range(0, 1));
            imem_rdata = $urandom;
            #1;
            if (imem_req || dmem_req || reg_write || pc_write || !trap || trap_cause !== cause)
                viol++;
            @(negedge CLK);
        end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        chk({tag, "/trap_hold"}, 32'(viol), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge CLK);
        resetl = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; zero = 1'b0;
        @(negedge CLK);
        chk({tag, "/rst_outputs"},
            32'({imem_req, dmem_req, dmem_we, reg_write, pc_write, pc_src, alu_src,
                 reg2loc, mem_to_reg, trap, trap_cause, sext_ctrl, alu_op}), 32'd0);
        chk({tag, "/rst_retired"}, retired, 32'd0);
        chk({tag, "/rst_ir"}, ir, 32'd0);
        resetl = 1'b1;
        #1;
        chk({tag, "/idle_no_req"}, 32'(imem_req), 32'd0);
        @(negedge CLK);
        chk({tag, "/fetch_req"}, 32'(imem_req), 32'd1);
        exp_retired = 0;
    endtask

    initial begin
        logic [31:0] ins;
        logic [10:0] op;
        int cls, k;

        do_reset("reset0");

        // directed instructions
        run_instr("add", 32'h8B020023, 0, 0, 1'b0);
        run_instr("ldur_d3", 32'hF8408025, 0, 3, 1'b0);
        run_instr("cbz_z1", 32'hB4000060, 0, 0, 1'b1);
        run_instr("cbz_z0", 32'hB4000060, 0, 0, 1'b0);
        run_instr("stur", 32'hF8008022, 1, 0, 1'b0);
        run_instr("b", 32'h14000002, 0, 0, 1'b0);

        // illegal opcode right after the branch
        trace(32'h00000000, 0, 0, 1'b0, 1'b0);
        chk("illegal/trap_cycle", 32'(t_trap), 32'd3);
        chk("illegal/no_pc_write", 32'(t_pcw), 32'd0);
        chk("illegal/cause", 32'(trap_cause), 32'd1);
        hold_trap("illegal", 2'b01);

        // fetch timeout: four FETCH cycles then trap
        do_reset("reset1");
        trace(32'h8B020023, NEVER, 0, 1'b0, 1'b0);
        chk("imem_to/req_cycles", 32'(t_nri), 32'(TO));
        chk("imem_to/trap_cycle", 32'(t_trap), 32'(TO + 1));
        chk("imem_to/cause", 32'(trap_cause), 32'd2);
        hold_trap("imem_to", 2'b10);

        // ack on the expiry cycle wins
        do_reset("reset2");
        run_instr("imem_expiry_ack", 32'h8B020023, TO - 1, 0, 1'b0);
        run_instr("dmem_expiry_ack", 32'hF8008022, 0, TO - 1, 1'b0);

        // data timeout on a store
        trace(32'hF8008022, 0, NEVER, 1'b0, 1'b1);
        chk("dmem_to/req_cycles", 32'(t_nrd), 32'(TO));
        chk("dmem_to/trap_cycle", 32'(t_trap), 32'(3 + TO + 1));
        chk("dmem_to/no_pc_write", 32'(t_pcw), 32'd0);
        chk("dmem_to/cause", 32'(trap_cause), 32'd3);
        hold_trap("dmem_to", 2'b11);

        // randomized legal instruction stream
        do_reset("reset3");
        for (int i = 0; i < 40; i++) begin
            cls = $urandom_range(C_R, C_B);
            op  = pick_op(cls);
            ins = {op, 21'($urandom)};
            run_instr("rnd", ins, $urandom_range(0, TO - 1), $urandom_range(0, TO - 1),
                      1'($urandom_range(0, 1)));
        end

        // randomized illegal opcodes
        for (int i = 0; i < 3; i++) begin
            k = 0;
            op = 11'($urandom);
            while (classify(op) != C_ILL && k < 100) begin
                op = 11'($urandom);
                k++;
            end
            ins = {op, 21'($urandom)};
            if (i > 0) do_reset("reset_ill");
            else run_instr("pre_ill", 32'h91000421, 0, 0, 1'b0);
            k = $urandom_range(0, TO - 1);
            trace(ins, k, 0, 1'b0, 1'b0);
            chk("rnd_illegal/trap_cycle", 32'(t_trap), 32'(k + 3));
            chk("rnd_illegal/cause", 32'(trap_cause), 32'd1);
            hold_trap("rnd_illegal", 2'b01);
        end

        // reset landing in MEM of a store
        do_reset("reset4");
        run_instr("pre_mid_a", 32'h8B020023, 0, 0, 1'b0);
        run_instr("pre_mid_b", 32'hCB020023, 0, 0, 1'b0);
        imem_rdata = 32'hF8008022;
        k = 0;
        while (!dmem_req && k < 10) begin
            imem_ack = imem_req;
            dmem_ack = 1'b0;
            @(negedge CLK);
            k++;
        end
        imem_ack = 1'b0;
        chk("midrst/reached_mem", 32'(dmem_req), 32'd1);
        chk("midrst/retired_before", retired, 32'd2);
        resetl = 1'b0;
        dmem_ack = 1'b1;
        #1;
        chk("midrst/no_pc_write", 32'(pc_write), 32'd0);
        @(negedge CLK);
        dmem_ack = 1'b0;
        chk("midrst/outputs",
            32'({imem_req, dmem_req, dmem_we, reg_write, pc_write, pc_src, alu_src,
                 reg2loc, mem_to_reg, trap, trap_cause, sext_ctrl, alu_op}), 32'd0);
        chk("midrst/retired", retired, 32'd0);
        resetl = 1'b1;
        #1;
        chk("midrst/idle", 32'(imem_req), 32'd0);
        @(negedge CLK);
        chk("midrst/fetch", 32'(imem_req), 32'd1);
        exp_retired = 0;
        run_instr("after_midrst", 32'h8A020023, 0, 0, 1'b0);
        run_instr("final", 32'hF8408025, 2, 1, 1'b0);
        chk("final/retired", retired, 32'(exp_retired));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
